// File: rtl/sram_controller.sv
// sram_controller: bridges a 32-bit pipeline load/store port onto a 16-bit
// asynchronous SRAM. Each 32-bit access is split into a LOW halfword phase
// followed by a HIGH halfword phase, and each phase is held for ACCESS_CYCLES
// clocks. The pipeline is frozen (ready=0) from the moment a request is seen
// in IDLE until the single DONE cycle.
//
// Handshake: the pipeline raises wr_en or rd_en and holds it, together with
// address/write_data, until it samples ready=1. ready=1 in IDLE means no
// request is pending. ready=1 in DONE means the access has completed, and a
// load result is valid on read_data in that same cycle. Operands are latched
// on entry to LOW, so input changes during the access have no effect.
module sram_controller #(
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    input  logic [15:0] sram_dq_in,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    // The counter only needs to reach ACCESS_CYCLES-1.
    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          op_wr_q, op_wr_d;
    logic [16:0]   word_q, word_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   read_data_q, read_data_d;

    logic          req;
    logic          cnt_last;
    logic [31:0]   addr_off;

    assign req      = wr_en | rd_en;
    assign cnt_last = (cnt_q == CNT_LAST);
    // Byte offset from the SRAM window base; bits [18:2] form the word
    // address, so anything above wraps modulo 2^17 words.
    assign addr_off = address - BASE_ADDR;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_wr_q     <= 1'b0;
            word_q      <= '0;
            data_q      <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_wr_q     <= op_wr_d;
            word_q      <= word_d;
            data_q      <= data_d;
            read_data_q <= read_data_d;
        end
    end

    // Next-state logic: phase sequencing, operand latch and read capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_wr_d     = op_wr_q;
        word_d      = word_q;
        data_d      = data_q;
        read_data_d = read_data_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    op_wr_d = wr_en;
                    word_d  = addr_off[18:2];
                    data_d  = write_data;
                end
            end
            LOW: begin
                if (cnt_last) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    if (!op_wr_q) begin
                        read_data_d[15:0] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HIGH: begin
                if (cnt_last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (!op_wr_q) begin
                        read_data_d[31:16] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode: SRAM bus drive per phase and the pipeline ready flag.
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        ready       = 1'b0;
        case (state_q)
            IDLE: begin
                ready = ~req;
            end
            LOW: begin
                sram_addr = {word_q, 1'b0};
                if (op_wr_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = data_q[15:0];
                end
            end
            HIGH: begin
                sram_addr = {word_q, 1'b1};
                if (op_wr_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = data_q[31:16];
                end
            end
            DONE: begin
                ready = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    assign read_data = read_data_q;
    assign dbg_state = state_q;

    // Chip, output and byte enables are permanently asserted.
    assign sram_ce_n = 1'b0;
    assign sram_oe_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Testbench for sram_controller: a table of directed load/store vectors with
// hand-computed halfword addresses and results, plus hand-written sequences
// for reset state, back-to-back requests and reset in the middle of a write.
module tb_sram_controller;

    localparam int AC = 2;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_in, sram_dq_out;
    logic        sram_dq_oe, sram_we_n;
    logic        sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    sram_controller #(
        .BASE_ADDR(32'd1024),
        .ACCESS_CYCLES(AC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .address(address),
        .write_data(write_data),
        .read_data(read_data),
        .ready(ready),
        .sram_addr(sram_addr),
        .sram_dq_in(sram_dq_in),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe),
        .sram_we_n(sram_we_n),
        .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n),
        .sram_ub_n(sram_ub_n),
        .sram_lb_n(sram_lb_n),
        .dbg_state(dbg_state)
    );

    // ---------------- SRAM model (small window, low 8 address bits) ----------------
    logic [15:0] mem [0:255];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    end

    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq_out;
    end

    assign sram_dq_in = mem[sram_addr[7:0]];

    // ---------------- scoreboard ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [17:0] exp_ha;    // halfword address in LOW phase
        logic        is_wr;     // expected operation
        logic [31:0] exp_rd;    // read_data expected in DONE
    } vec_t;

    vec_t vecs[9];

    // One full access: request in cycle 0, AC LOW + AC HIGH cycles, DONE, idle.
    task automatic run_txn(input vec_t v, input int idx);
        logic        hi;
        logic [15:0] exp_dq;
        @(posedge clk); #1;
        wr_en = v.wr; rd_en = v.rd; address = v.addr; write_data = v.wdata;
        @(negedge clk);
        chk($sformatf("v%0d c0 ready", idx), 32'(ready), 32'd0);
        chk($sformatf("v%0d c0 we_n", idx), 32'(sram_we_n), 32'd1);
        for (int c = 1; c <= 2 * AC; c++) begin
            @(posedge clk); #1;
            // Operands are latched; scrambling them must not matter.
            address = $urandom; write_data = $urandom;
            @(negedge clk);
            hi = (c > AC);
            exp_dq = !v.is_wr ? 16'h0 : (hi ? v.wdata[31:16] : v.wdata[15:0]);
            chk($sformatf("v%0d c%0d sram_addr", idx, c), 32'(sram_addr), 32'(v.exp_ha + 18'(hi)));
            chk($sformatf("v%0d c%0d we_n", idx, c), 32'(sram_we_n), 32'(!v.is_wr));
            chk($sformatf("v%0d c%0d dq_oe", idx, c), 32'(sram_dq_oe), 32'(v.is_wr));
            chk($sformatf("v%0d c%0d dq_out", idx, c), 32'(sram_dq_out), 32'(exp_dq));
            chk($sformatf("v%0d c%0d ready", idx, c), 32'(ready), 32'd0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk($sformatf("v%0d done ready", idx), 32'(ready), 32'd1);
        chk($sformatf("v%0d done read_data", idx), read_data, v.exp_rd);
        chk($sformatf("v%0d done sram_addr", idx), 32'(sram_addr), 32'd0);
        chk($sformatf("v%0d done we_n", idx), 32'(sram_we_n), 32'd1);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d idle ready", idx), 32'(ready), 32'd1);
        chk($sformatf("v%0d idle state", idx), 32'(dbg_state), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int first_rdy;
        int second_rdy;

        vecs[0] = '{1'b1, 1'b0, 32'd1028,   32'hDEADBEEF, 18'd2, 1'b1, 32'h00000000};
        vecs[1] = '{1'b0, 1'b1, 32'd1028,   32'h55AA55AA, 18'd2, 1'b0, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 32'd1032,   32'h12345678, 18'd4, 1'b1, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 1'b1, 32'd1032,   32'h55AA55AA, 18'd4, 1'b0, 32'h12345678};
        vecs[4] = '{1'b1, 1'b0, 32'd525312, 32'hCAFEF00D, 18'd0, 1'b1, 32'h12345678};
        vecs[5] = '{1'b0, 1'b1, 32'd1031,   32'h55AA55AA, 18'd2, 1'b0, 32'hDEADBEEF};
        vecs[6] = '{1'b0, 1'b1, 32'd1024,   32'h55AA55AA, 18'd0, 1'b0, 32'hCAFEF00D};
        vecs[7] = '{1'b1, 1'b0, 32'd1024,   32'h0BADF00D, 18'd0, 1'b1, 32'hCAFEF00D};
        vecs[8] = '{1'b0, 1'b1, 32'd525312, 32'h55AA55AA, 18'd0, 1'b0, 32'h0BADF00D};

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst ready", 32'(ready), 32'd1);
        chk("rst we_n", 32'(sram_we_n), 32'd1);
        chk("rst dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst sram_addr", 32'(sram_addr), 32'd0);
        chk("rst dq_out", 32'(sram_dq_out), 32'd0);
        chk("rst read_data", read_data, 32'd0);
        chk("rst state", 32'(dbg_state), 32'd0);
        chk("tied enables", 32'({sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n}), 32'd0);

        for (int i = 0; i < 9; i++) run_txn(vecs[i], i);

        // Back-to-back: write 1040 then read 1040 with no idle gap.
        first_rdy = -1; second_rdy = -1;
        for (int c = 0; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c < 6) begin
                wr_en = 1'b1; rd_en = 1'b0; address = 32'd1040; write_data = 32'h13579BDF;
            end else if (c < 12) begin
                wr_en = 1'b0; rd_en = 1'b1; address = 32'd1040;
            end else begin
                wr_en = 1'b0; rd_en = 1'b0;
            end
            @(negedge clk);
            if (c == 6) chk("b2b ready at restart", 32'(ready), 32'd0);
            if (c == 11) chk("b2b read_data", read_data, 32'h13579BDF);
            if (ready && c < 12) begin
                if (first_rdy < 0) first_rdy = c;
                else if (second_rdy < 0) second_rdy = c;
            end
        end
        chk("b2b first ready cycle", 32'(first_rdy), 32'd5);
        chk("b2b second ready cycle", 32'(second_rdy), 32'd11);

        // Reset during HIGH of a write to 1036 (halfwords 6/7).
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1036; write_data = 32'hAAAA5555;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort in HIGH addr", 32'(sram_addr), 32'd7);
        chk("abort in HIGH we_n", 32'(sram_we_n), 32'd0);
        rst = 1'b1; wr_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort state", 32'(dbg_state), 32'd0);
        chk("abort we_n", 32'(sram_we_n), 32'd1);
        chk("abort dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("abort sram_addr", 32'(sram_addr), 32'd0);
        chk("abort dq_out", 32'(sram_dq_out), 32'd0);
        chk("abort read_data", read_data, 32'd0);
        chk("abort ready", 32'(ready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("abort no resume %0d", c), 32'(sram_we_n), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'd1024, giving the byte address mapped to SRAM word 0.
REQ-002 SHALL have parameter ACCESS_CYCLES, default 2, giving the cycles per 16-bit SRAM access; legal values are 1 or more.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port wr_en, input, 1 bit: pipeline store request, held until ready.
REQ-006 SHALL have port rd_en, input, 1 bit: pipeline load request, held until ready.
REQ-007 SHALL have port address, input, 32 bits: byte address.
REQ-008 SHALL have port write_data, input, 32 bits: store data.
REQ-009 SHALL have port read_data, output, 32 bits: load result, registered.
REQ-010 SHALL have port ready, output, 1 bit: low means freeze the pipeline.
REQ-011 SHALL have port sram_addr, output, 18 bits: SRAM halfword address.
REQ-012 SHALL have port sram_dq_in, input, 16 bits: SRAM read data.
REQ-013 SHALL have port sram_dq_out, output, 16 bits: SRAM write data.
REQ-014 SHALL have port sram_dq_oe, output, 1 bit: drive enable for the data bus.
REQ-015 SHALL have port sram_we_n, output, 1 bit: active-low write strobe.
REQ-016 SHALL have ports sram_ce_n, sram_oe_n, sram_ub_n and sram_lb_n, outputs, 1 bit each, tied to 0.

Function
REQ-017 SHALL implement the FSM states IDLE, LOW, HIGH and DONE.
REQ-018 The request SHALL be req = wr_en | rd_en; the operation is a write if wr_en=1, so a write wins when wr_en and rd_en are both set.
REQ-019 In IDLE with req=1, the next state SHALL be LOW; in IDLE with req=0, the state SHALL stay IDLE.
REQ-020 The block SHALL latch the operation type, word address and write_data on the IDLE->LOW edge; later changes to the inputs are ignored until DONE.
REQ-021 The word address SHALL be ((address - BASE_ADDR) >> 2) truncated to 17 bits: modulo-2^17 wrap, address[1:0] ignored.
REQ-022 LOW and HIGH SHALL each last exactly ACCESS_CYCLES cycles, timed by a cycle counter cleared on every state entry; then LOW->HIGH and HIGH->DONE.
REQ-023 DONE SHALL last 1 cycle, then go to IDLE unconditionally.
REQ-024 During LOW, sram_addr SHALL be {word,1'b0}; during HIGH, sram_addr SHALL be {word,1'b1}; in IDLE and DONE, sram_addr SHALL be 0.
REQ-025 For a write, during LOW and HIGH: sram_we_n=0 and sram_dq_oe=1; sram_dq_out = data[15:0] in LOW and data[31:16] in HIGH.
REQ-026 At all other times sram_we_n SHALL be 1, sram_dq_oe 0 and sram_dq_out 0.
REQ-027 For a read, the block SHALL capture sram_dq_in into read_data[15:0] on the last LOW cycle and into read_data[31:16] on the last HIGH cycle.
REQ-028 read_data SHALL hold its value until the next read overwrites it; writes leave it unchanged.
REQ-029 ready SHALL be combinational: 1 in DONE; 1 in IDLE when req=0; 0 in IDLE when req=1; 0 in LOW and HIGH.
REQ-030 Latency, counting the request's first IDLE cycle as cycle 0: ready=1 at cycle 2*ACCESS_CYCLES+1, which is cycle 5 by default.
REQ-031 read_data SHALL be valid in the DONE cycle.
REQ-032 Back-to-back: a req still high in the IDLE cycle after DONE SHALL start a new access, with ready=0 in that cycle.

Reset
REQ-033 On rst=1 at a clock edge, in any state including mid-access, the state SHALL become IDLE, the counter 0, read_data 0 and all latched operands 0.
REQ-034 After reset the outputs SHALL be: sram_we_n=1, sram_dq_oe=0, sram_addr=0 and sram_dq_out=0.
REQ-035 After reset, ready SHALL be 1 whenever req=0.
REQ-036 An aborted write SHALL NOT be resumed after reset; SRAM contents are then undefined for that word.

Verification
REQ-037 Write: wr_en=1, address=1028, write_data=0xDEADBEEF -> sram_addr=2 with dq_out=0xBEEF for 2 cycles, then sram_addr=3 with dq_out=0xDEAD for 2 cycles, sram_we_n=0 throughout; ready=1 at cycle 5.
REQ-038 Read-back: rd_en=1, address=1028, with an SRAM model returning the stored halves -> read_data=0xDEADBEEF at cycle 5; sram_we_n stays 1.
REQ-039 Priority: wr_en=1 and rd_en=1, address=1032, data=0x12345678 -> write to halfwords 4 and 5; read_data unchanged.
REQ-040 Wrap: address=1024+4*131072 -> halfwords 0 and 1 accessed; address=1031 -> same as 1028.
REQ-041 Reset mid-op: rst=1 during HIGH of a write -> next cycle IDLE, sram_we_n=1, read_data=0, ready=1 with req=0.
REQ-042 Back-to-back: write then read held with no idle gap -> two ready pulses 6 cycles apart; the read returns the written value.
